// File: rtl/pixel_burst_writer.sv
// pixel_burst_writer
//
// Turns one pixel-write request from the render control FSM into a single
// AXI4 INCR write burst. Every beat of the burst carries the same color. The
// block pulses txn_done once the write response has returned.
//
// Optional feature: define WRITER_STATS_EN to add the burst_count and
// beat_count statistics outputs. The default build omits them.
//
// Ports:
//   clk100        system clock; all logic runs on the rising edge
//   reset         synchronous, active-high reset
//   txn_init      request strobe; only a rising edge starts a burst
//   offset_addr   byte offset of the first pixel, sampled on the accepted edge
//   color         12-bit pixel color, sampled on the accepted edge
//   pixel_count   beats requested; clamped to burst_len
//   txn_done      one-cycle pulse at the end of a request
//   txn_error     last burst returned a non-OKAY bresp; held until the next request
//   busy          high from the accepted edge through the txn_done pulse
//   m_aw*/m_w*/m_b*  AXI4 write address, data and response channels
//   burst_count   (WRITER_STATS_EN) completed bursts that carried at least one beat
//   beat_count    (WRITER_STATS_EN) W handshakes
module pixel_burst_writer #(
  parameter int unsigned burst_len = 16,
  parameter logic [31:0] base_addr = 32'h8000_0000
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        txn_init,
  input  logic [31:0] offset_addr,
  input  logic [11:0] color,
  input  logic [31:0] pixel_count,
  output logic        txn_done,
  output logic        txn_error,
  output logic        busy,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
`ifdef WRITER_STATS_EN
  ,
  output logic [31:0] burst_count,
  output logic [31:0] beat_count
`endif
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [31:0] burst_len_c = 32'(burst_len);

  // Clamp the requested pixel count to the largest burst this block issues.
  function automatic logic [8:0] clamp_beats(input logic [31:0] cnt);
    if (cnt > burst_len_c) begin
      clamp_beats = 9'(burst_len);
    end else begin
      clamp_beats = cnt[8:0];
    end
  endfunction

  logic [2:0]  state_r;
  logic        ff1_r;
  logic        ff2_r;
  logic        pulse_s;
  logic [8:0]  beats_r;
  logic [8:0]  beat_cnt_r;
  logic [8:0]  req_beats_s;
  logic        txn_done_r;
  logic        txn_error_r;
  logic        busy_r;
  logic [31:0] awaddr_r;
  logic [7:0]  awlen_r;
  logic        awvalid_r;
  logic [31:0] wdata_r;
  logic        wlast_r;
  logic        wvalid_r;
  logic        bready_r;

  assign pulse_s     = ff1_r & ~ff2_r;
  assign req_beats_s = clamp_beats(pixel_count);

  assign txn_done  = txn_done_r;
  assign txn_error = txn_error_r;
  assign busy      = busy_r;
  assign m_awaddr  = awaddr_r;
  assign m_awlen   = awlen_r;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_awvalid = awvalid_r;
  assign m_wdata   = wdata_r;
  assign m_wstrb   = 4'hF;
  assign m_wlast   = wlast_r;
  assign m_wvalid  = wvalid_r;
  assign m_bready  = bready_r;

  // Request edge detection, burst sequencing and all registered outputs.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ff1_r       <= 1'b0;
      ff2_r       <= 1'b0;
      beats_r     <= 9'd0;
      beat_cnt_r  <= 9'd0;
      txn_done_r  <= 1'b0;
      txn_error_r <= 1'b0;
      busy_r      <= 1'b0;
      awaddr_r    <= 32'd0;
      awlen_r     <= 8'd0;
      awvalid_r   <= 1'b0;
      wdata_r     <= 32'd0;
      wlast_r     <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
    end else begin
      ff1_r      <= txn_init;
      ff2_r      <= ff1_r;
      txn_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // busy still set here means this is the txn_done cycle. Drop
          // any request edge that lands in it.
          if (busy_r) begin
            busy_r <= 1'b0;
          end else if (pulse_s) begin
            busy_r      <= 1'b1;
            txn_error_r <= 1'b0;
            awaddr_r    <= base_addr + offset_addr;
            wdata_r     <= {20'h00000, color};
            beats_r     <= req_beats_s;
            beat_cnt_r  <= 9'd0;
            if (pixel_count == 32'd0) begin
              awlen_r <= 8'd0;
              state_r <= ST_DONE;
            end else begin
              awlen_r   <= 8'(req_beats_s - 9'd1);
              awvalid_r <= 1'b1;
              state_r   <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (m_awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            wlast_r   <= (beats_r == 9'd1);
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_wready) begin
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= ST_RESP;
            end else begin
              // wlast is registered, so look one beat ahead:
              // the next beat is the last one when beat_cnt+1 == beats-1.
              beat_cnt_r <= beat_cnt_r + 9'd1;
              wlast_r    <= ((beat_cnt_r + 9'd2) == beats_r);
            end
          end
        end
        ST_RESP: begin
          if (m_bvalid) begin
            bready_r    <= 1'b0;
            txn_error_r <= (m_bresp != 2'b00);
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          txn_done_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          wlast_r   <= 1'b0;
          bready_r  <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WRITER_STATS_EN
  logic [31:0] burst_count_r;
  logic [31:0] beat_count_r;

  assign burst_count = burst_count_r;
  assign beat_count  = beat_count_r;

  // Statistics: count completed non-empty bursts and W handshakes. Both wrap.
  always_ff @(posedge clk100) begin
    if (reset) begin
      burst_count_r <= 32'd0;
      beat_count_r  <= 32'd0;
    end else begin
      if ((state_r == ST_DONE) && (beats_r != 9'd0)) begin
        burst_count_r <= burst_count_r + 32'd1;
      end
      if (wvalid_r && m_wready) begin
        beat_count_r <= beat_count_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_burst_writer.sv
// Directed self-checking bench for pixel_burst_writer. Inputs change on the
// falling clock edge, and outputs are sampled on the falling edge.
module tb_pixel_burst_writer;

  logic        clk100 = 1'b0;
  logic        reset = 1'b1;
  logic        txn_init = 1'b0;
  logic [31:0] offset_addr = 32'd0;
  logic [11:0] color = 12'd0;
  logic [31:0] pixel_count = 32'd0;
  logic        txn_done, txn_error, busy;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        m_awready = 1'b1;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid;
  logic        m_wready = 1'b1;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b1;
  logic        m_bready;
`ifdef WRITER_STATS_EN
  logic [31:0] burst_count, beat_count;
`endif

  always #5 clk100 = ~clk100;

  pixel_burst_writer dut (
    .clk100(clk100), .reset(reset), .txn_init(txn_init),
    .offset_addr(offset_addr), .color(color), .pixel_count(pixel_count),
    .txn_done(txn_done), .txn_error(txn_error), .busy(busy),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef WRITER_STATS_EN
    , .burst_count(burst_count), .beat_count(beat_count)
`endif
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request. txn_init goes high before the first edge and drops at
  // drop_cyc. If raise_cyc >= 0, txn_init goes high again at that cycle.
  // exp_lat is the expected count of cycles from awvalid rising to txn_done
  // (-1 skips the check).
  task automatic run_burst(input string tag, input logic [31:0] off, input logic [11:0] col,
                           input logic [31:0] cnt, input int stall, input logic [1:0] resp,
                           input int exp_beats, input int exp_lat, input int drop_cyc,
                           input int raise_cyc);
    int aw_cyc = -1, done_cyc = -1, busy_cyc = -1, busy_n = 0;
    int beats = 0, dones = 0, aw_rises = 0;
    int data_bad = 0, wlast_bad = 0, stab_bad = 0, aw_bad = 0;
    logic err_at_acc = 1'b0, err_at_done = 1'b0, prev_aw = 1'b0;
    logic prev_stall_w = 1'b0, prev_stall_aw = 1'b0, prev_wlast = 1'b0;
    logic [31:0] prev_wdata = 32'd0, prev_awaddr = 32'd0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
    exp_addr = 32'h8000_0000 + off;
    exp_len  = 8'(exp_beats - 1);
    @(negedge clk100);
    offset_addr = off; color = col; pixel_count = cnt; m_bresp = resp; txn_init = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk100);
      if (cyc == drop_cyc) txn_init = 1'b0;
      if (cyc == raise_cyc) txn_init = 1'b1;
      if (busy) begin
        busy_n++;
        if (busy_cyc < 0) begin busy_cyc = cyc; err_at_acc = txn_error; end
      end
      if (m_awvalid && !prev_aw) aw_rises++;
      if (m_awvalid && aw_cyc < 0) aw_cyc = cyc;
      if (m_awvalid && (m_awaddr !== exp_addr || m_awlen !== exp_len)) aw_bad++;
      if (prev_stall_w && (m_wvalid !== 1'b1 || m_wdata !== prev_wdata || m_wlast !== prev_wlast)) stab_bad++;
      if (prev_stall_aw && (m_awvalid !== 1'b1 || m_awaddr !== prev_awaddr)) stab_bad++;
      if (txn_done) begin
        dones++;
        if (done_cyc < 0) begin done_cyc = cyc; err_at_done = txn_error; end
      end
      if (stall != 0) begin
        m_awready = 1'($urandom_range(0, 1));
        m_wready  = 1'($urandom_range(0, 1));
        m_bvalid  = 1'($urandom_range(0, 1));
      end else begin
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
      end
      if (m_wvalid && m_wready) begin
        beats++;
        if (m_wdata !== {20'h00000, col}) data_bad++;
        if (m_wlast !== (beats == exp_beats)) wlast_bad++;
      end
      prev_stall_w  = m_wvalid && !m_wready;
      prev_wdata    = m_wdata;
      prev_wlast    = m_wlast;
      prev_stall_aw = m_awvalid && !m_awready;
      prev_awaddr   = m_awaddr;
      prev_aw       = m_awvalid;
      if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
    end
    txn_init = 1'b0; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    check_val({tag, " beats"}, beats, exp_beats);
    check_val({tag, " done_pulses"}, dones, 32'd1);
    check_val({tag, " aw_bursts"}, aw_rises, (exp_beats == 0) ? 32'd0 : 32'd1);
    check_val({tag, " aw_fields_bad"}, aw_bad, 32'd0);
    check_val({tag, " wdata_bad"}, data_bad, 32'd0);
    check_val({tag, " wlast_bad"}, wlast_bad, 32'd0);
    check_val({tag, " stall_stability_bad"}, stab_bad, 32'd0);
    check_val({tag, " err_cleared_on_accept"}, 32'(err_at_acc), 32'd0);
    check_val({tag, " err_at_done"}, 32'(err_at_done), (resp != 2'b00) ? 32'd1 : 32'd0);
    check_val({tag, " busy_span"}, busy_n, done_cyc - busy_cyc + 1);
    if (exp_lat >= 0) check_val({tag, " latency"}, done_cyc - aw_cyc, exp_lat);
    if (exp_beats == 0) begin
      check_val({tag, " done_after_accept"}, done_cyc - busy_cyc, 32'd1);
      check_val({tag, " busy_cycles"}, busy_n, 32'd2);
    end
    repeat (3) @(negedge clk100);
  endtask

  initial begin
    int dones;
    // Reset values
    repeat (3) @(negedge clk100);
    check_val("rst txn_done", 32'(txn_done), 32'd0);
    check_val("rst txn_error", 32'(txn_error), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst valids", {28'd0, m_awvalid, m_wvalid, m_wlast, m_bready}, 32'd0);
    check_val("rst awaddr", m_awaddr, 32'd0);
    check_val("rst awlen", 32'(m_awlen), 32'd0);
    check_val("rst wdata", m_wdata, 32'd0);
    check_val("const awsize", 32'(m_awsize), 32'd2);
    check_val("const awburst", 32'(m_awburst), 32'd1);
    check_val("const wstrb", 32'(m_wstrb), 32'hF);
    reset = 1'b0;
    repeat (2) @(negedge clk100);

    run_burst("b16",      32'h0000_0100, 12'hABC, 32'd16, 0, 2'b00, 16, 19, 1, -1);
    run_burst("clamp40",  32'h0000_0200, 12'h5A5, 32'd40, 0, 2'b00, 16, 19, 1, -1);
    run_burst("zero",     32'h0000_0300, 12'h111, 32'd0,  0, 2'b00, 0,  -1, 1, -1);
    run_burst("stall5",   32'h0000_0400, 12'h777, 32'd5,  1, 2'b00, 5,  -1, 1, -1);
    run_burst("berr",     32'h0000_0500, 12'hF0F, 32'd3,  0, 2'b10, 3,  6,  1, -1);
    run_burst("errclr",   32'h0000_0600, 12'h0F0, 32'd2,  0, 2'b00, 2,  5,  1, -1);
    run_burst("held",     32'h0000_0700, 12'h321, 32'd8,  0, 2'b00, 8,  11, 5, 6);
    run_burst("doneedge", 32'h0000_0800, 12'h456, 32'd1,  0, 2'b00, 1,  4,  1, 3);
    run_burst("wrap",     32'h8000_0010, 12'h999, 32'd4,  0, 2'b00, 4,  7,  1, -1);

    // Reset while the burst is in the data phase
    @(negedge clk100);
    offset_addr = 32'h40; color = 12'h123; pixel_count = 32'd8; txn_init = 1'b1;
    repeat (3) @(negedge clk100);
    txn_init = 1'b0;
    check_val("rst_mid in_data", 32'(m_wvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk100);
    check_val("rst_mid valids", {28'd0, m_awvalid, m_wvalid, m_wlast, m_bready}, 32'd0);
    check_val("rst_mid busy_done", {30'd0, busy, txn_done}, 32'd0);
    check_val("rst_mid awaddr", m_awaddr, 32'd0);
    check_val("rst_mid wdata", m_wdata, 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk100);
      if (txn_done) dones++;
    end
    check_val("rst_mid no_done", dones, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
